// File: rtl/execute_unit.sv
// Execute stage: two operand muxes, ALU, status register, valid/ready issue.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier (op 9).
module execute_unit #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 10,
  parameter int INC_CONST = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        src_a_sel,
  input  logic [1:0]        src_b_sel,
  input  logic [WIDTH-1:0]  mdr_in,
  input  logic [WIDTH-1:0]  imm_in,
  input  logic [1:0]        cc_in,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [WIDTH-1:0]  reg_in,
  input  logic [3:0]        alu_op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              out_sel,
  input  logic              sr_w,
  output logic [WIDTH-1:0]  alu_out,
  output logic [3:0]        sr_out,
  output logic              out_valid,
  output logic              busy
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]  a, b, res, addr_ext;
  logic [WIDTH:0]    ext;
  logic signed [WIDTH:0] sext;
  logic [SHW-1:0]    amt;
  logic [3:0]        flags;
  logic              c, v, issue, is_mul;

  assign issue    = in_valid && in_ready;
  assign addr_ext = WIDTH'(addr_in);
  assign amt      = b[SHW-1:0];
  assign flags    = {res[WIDTH-1], res == '0, c, v};

  always_comb begin
    unique case (src_a_sel)
      2'd0: a = mdr_in;
      2'd1: a = imm_in;
      2'd2: a = WIDTH'(cc_in);
      default: a = pc_in;
    endcase
    unique case (src_b_sel)
      2'd0: b = WIDTH'(sr_out);
      2'd1: b = reg_in;
      2'd2: b = WIDTH'(INC_CONST);
      default: b = alu_out;
    endcase
  end

  // Shifts run one bit wider so the last bit shifted out lands in ext/sext.
  always_comb begin
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    ext  = '0;
    sext = '0;
    case (alu_op)
      4'd0: begin
        ext = {1'b0, a} + {1'b0, b};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) &&
              (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        res = a - b;
        c   = a >= b;
        v   = (a[WIDTH-1] != b[WIDTH-1]) &&
              (res[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin
        ext = {1'b0, a} << amt;
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
      end
      4'd6: begin
        ext = {a, 1'b0} >> amt;
        res = ext[WIDTH:1];
        c   = ext[0];
      end
      4'd7: begin
        sext = $signed({a, 1'b0}) >>> amt;
        res  = sext[WIDTH:1];
        c    = sext[0];
      end
      4'd8: res = b;
      default: ;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0]   mplier, addr_q;
  logic [SHW-1:0]     cnt;
  logic               out_sel_q, sr_w_q;

  assign is_mul   = alu_op == 4'd9;
  assign in_ready = state == IDLE;
  assign busy     = state == MUL;
  assign prod     = acc + (mplier[0] ? mcand : '0);
`else
  assign is_mul   = 1'b0;
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      alu_out   <= '0;
      sr_out    <= '0;
      out_valid <= 1'b0;
`ifdef EXEC_MUL_EN
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      addr_q    <= '0;
      out_sel_q <= 1'b0;
      sr_w_q    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (issue && !is_mul) begin
        out_valid <= 1'b1;
        if (out_sel) begin
          alu_out <= addr_ext;
        end else begin
          alu_out <= res;
          if (sr_w) sr_out <= flags;
        end
      end
`ifdef EXEC_MUL_EN
      unique case (state)
        IDLE: if (issue && is_mul) begin
          state     <= MUL;
          acc       <= '0;
          mcand     <= (2*WIDTH)'(a);
          mplier    <= b;
          cnt       <= '0;
          addr_q    <= addr_ext;
          out_sel_q <= out_sel;
          sr_w_q    <= sr_w;
        end
        MUL: begin
          acc    <= prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            if (out_sel_q) begin
              alu_out <= addr_q;
            end else begin
              alu_out <= prod[WIDTH-1:0];
              if (sr_w_q)
                sr_out <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0,
                           |prod[2*WIDTH-1:WIDTH], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end
endmodule
